// File: rtl/mcc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcc_pkg;

   // Controller states; 13 and 14 are unused and recover into TRAP
   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_WB_MEM   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC_R   = 4'd7,
      S_WB_R     = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_EXEC_I   = 4'd11,
      S_WB_I     = 4'd12,
      S_TRAP     = 4'd15
   } state_e;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_ADDI = 6'h08;

   // R-type funct codes (IR[5:0])
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ALU control codes
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_BAD = 4'b1111;

   // ALUOp encodings
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALUSrcB encodings
   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PCSource encodings
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Trap causes
   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU-control decode: ALUOp plus funct field to ALU operation code.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; follows its inputs every cycle.
module alu_ctrl_dec
   import mcc_pkg::*;
#(
   parameter int OPC_W     = 6,
   parameter int ALUCTRL_W = 4
) (
   input  logic [1:0]           alu_op_i,
   input  logic [OPC_W-1:0]     funct_i,
   output logic [ALUCTRL_W-1:0] alu_ctrl_o
);

   logic [3:0] code;

   // Map ALUOp (and funct for R-type) onto the 4-bit ALU code; unknown funct is not a trap
   always_comb begin
      code = ALU_BAD;
      case (alu_op_i)
         ALUOP_ADD: code = ALU_ADD;
         ALUOP_SUB: code = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct_i)
               OPC_W'(FN_ADD): code = ALU_ADD;
               OPC_W'(FN_SUB): code = ALU_SUB;
               OPC_W'(FN_AND): code = ALU_AND;
               OPC_W'(FN_OR):  code = ALU_OR;
               OPC_W'(FN_SLT): code = ALU_SLT;
               default:        code = ALU_BAD;
            endcase
         end
         default: code = ALU_BAD;
      endcase
   end

   // Wider control buses carry the code zero-extended
   assign alu_ctrl_o = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM (fetch/decode/exec/mem/wb) with memory timeout and illegal-op trap.
// Latency: R 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles with mem_ready high; each memory wait adds a cycle.
// Backpressure: FETCH/MEM_RD/MEM_WR hold while mem_ready is low, trapping after WAIT_MAX extra cycles.
module multicycle_ctrl
   import mcc_pkg::*;
#(
   parameter int OPC_W     = 6,
   parameter int ALUCTRL_W = 4,
   parameter int WAIT_MAX  = 15,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [OPC_W-1:0]     opcode,
   input  logic [OPC_W-1:0]     funct,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 PCWrite,
   output logic                 PCWriteCond,
   output logic                 pc_en,
   output logic                 IorD,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 MemtoReg,
   output logic                 RegDst,
   output logic                 RegWrite,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           PCSource,
   output logic [1:0]           ALUOp,
   output logic [ALUCTRL_W-1:0] ALUCtrl,
   output logic                 trap,
   output logic [1:0]           trap_cause,
   output logic [3:0]           state_o
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             trap_q, trap_d;
   logic [1:0]       cause_q, cause_d;
   logic             mem_wait;
   logic             timeout;

   // States that sit on the memory handshake, and the cycle where the wait budget runs out
   assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
   assign timeout  = mem_wait && !mem_ready && (cnt_q == CNT_W'(WAIT_MAX));

   // Next state, wait counter and sticky trap bookkeeping
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH: begin
            if (mem_ready)    state_d = S_DECODE;
            else if (timeout) begin
               state_d = S_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            case (opcode)
               OPC_W'(OP_R):    state_d = S_EXEC_R;
               OPC_W'(OP_LW):   state_d = S_MEM_ADDR;
               OPC_W'(OP_SW):   state_d = S_MEM_ADDR;
               OPC_W'(OP_BEQ):  state_d = S_BRANCH;
               OPC_W'(OP_J):    state_d = S_JUMP;
               OPC_W'(OP_ADDI): state_d = S_EXEC_I;
               default: begin
                  state_d = S_TRAP;
                  cause_d = CAUSE_ILLEGAL;
               end
            endcase
         end
         S_MEM_ADDR: state_d = (opcode == OPC_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: begin
            if (mem_ready)    state_d = S_WB_MEM;
            else if (timeout) begin
               state_d = S_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         S_MEM_WR: begin
            if (mem_ready)    state_d = S_FETCH;
            else if (timeout) begin
               state_d = S_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_EXEC_R: state_d = S_WB_R;
         S_EXEC_I: state_d = S_WB_I;
         S_TRAP:   state_d = S_TRAP;
         default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
         end
      endcase

      // Staying in a wait state only happens while mem_ready is low, so count it; any entry clears
      if (mem_wait && (state_d == state_q)) cnt_d = cnt_q + CNT_W'(1);
      else                                  cnt_d = '0;

      trap_d = trap_q || (state_d == S_TRAP);
   end

   // State, counter and trap registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         trap_q  <= 1'b0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         trap_q  <= trap_d;
         cause_q <= cause_d;
      end
   end

   // Moore datapath controls; FETCH qualifies IR/PC loads with mem_ready, MEM_WR drops the strobe on timeout
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      PCSource    = PCSRC_ALU;
      ALUOp       = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: ALUSrcB = SRCB_IMM_SH2;
         S_MEM_ADDR, S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_WB_MEM: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEM_WR: begin
            MemWrite = !timeout;
            IorD     = 1'b1;
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         S_WB_R: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
         S_WB_I: RegWrite = 1'b1;
         default: ;
      endcase
   end

   assign pc_en      = PCWrite | (PCWriteCond & zero);
   assign trap       = trap_q;
   assign trap_cause = cause_q;
   assign state_o    = state_q;

   alu_ctrl_dec #(
      .OPC_W     (OPC_W),
      .ALUCTRL_W (ALUCTRL_W)
   ) u_alu_dec (
      .alu_op_i   (ALUOp),
      .funct_i    (funct),
      .alu_ctrl_o (ALUCtrl)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: expected state/trap per cycle queued up front, outputs from a reference table.
// Latency: n/a.
// Backpressure: n/a.
module tb_multicycle_ctrl;

   localparam logic [3:0] IDLE = 4'd0,  FETCH = 4'd1,  DECODE = 4'd2,  MEM_ADDR = 4'd3,
                          MEM_RD = 4'd4, WB_MEM = 4'd5, MEM_WR = 4'd6,  EXEC_R = 4'd7,
                          WB_R = 4'd8,   BRANCH = 4'd9, JUMP = 4'd10,   EXEC_I = 4'd11,
                          WB_I = 4'd12,  TRAP = 4'd15;

   typedef struct packed {
      logic [3:0] st;
      logic       trap;
      logic [1:0] cause;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource, ALUOp, trap_cause;
   logic [3:0] ALUCtrl, state_o;
   logic       trap;

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   exp_t e;

   logic [27:0] dut_vec;
   assign dut_vec = {state_o, trap, trap_cause, PCWrite, PCWriteCond, pc_en, IorD, MemRead,
                     MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
                     PCSource, ALUOp, ALUCtrl};

   multicycle_ctrl #(.OPC_W(6), .ALUCTRL_W(4), .WAIT_MAX(15), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .pc_en(pc_en),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .ALUCtrl(ALUCtrl),
      .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [3:0] st, input logic t, input logic [1:0] c);
      exp_t r;
      r.st = st; r.trap = t; r.cause = c;
      return r;
   endfunction

   function automatic logic [3:0] alu_ref(input logic [1:0] aop, input logic [5:0] fn);
      if (aop == 2'b00) return 4'b0010;
      if (aop == 2'b01) return 4'b0110;
      if (aop == 2'b11) return 4'b1111;
      case (fn)
         6'h20: return 4'b0010;
         6'h22: return 4'b0110;
         6'h24: return 4'b0000;
         6'h25: return 4'b0001;
         6'h2A: return 4'b0111;
         default: return 4'b1111;
      endcase
   endfunction

   // Full expected observable vector for an expected state under the current inputs
   function automatic logic [27:0] exp_vec(input exp_t x);
      logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
      logic [1:0] asb, pcs, aop;
      {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
      asb = 2'b00; pcs = 2'b00; aop = 2'b00;
      case (x.st)
         FETCH:    begin mrd = 1; asb = 2'b01; irw = mem_ready; pcw = mem_ready; end
         DECODE:   asb = 2'b11;
         MEM_ADDR: begin asa = 1; asb = 2'b10; end
         MEM_RD:   begin mrd = 1; iord = 1; end
         WB_MEM:   begin rw = 1; m2r = 1; end
         MEM_WR:   begin mwr = 1; iord = 1; end
         EXEC_R:   begin asa = 1; aop = 2'b10; end
         WB_R:     begin rw = 1; rdst = 1; end
         BRANCH:   begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         JUMP:     begin pcw = 1; pcs = 2'b10; end
         EXEC_I:   begin asa = 1; asb = 2'b10; end
         WB_I:     rw = 1;
         default:  ;
      endcase
      return {x.st, x.trap, x.cause, pcw, pcwc, pcw | (pcwc & zero), iord, mrd, mwr, irw,
              m2r, rdst, rw, asa, asb, pcs, aop, alu_ref(aop, funct)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h22; zero = 1'b0;
      #3;
      e = mk(IDLE, 1'b0, 2'b00);
      total++;
      if (dut_vec !== exp_vec(e)) begin
         bad++; $display("FAIL reset_state: got %h want %h", dut_vec, exp_vec(e));
      end
      tick(); tick();
      total++;
      if (state_o !== IDLE) begin
         bad++; $display("FAIL reset_hold: got state %0d want %0d", state_o, IDLE);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_rtype();
      logic [3:0] seq [5] = '{FETCH, DECODE, EXEC_R, WB_R, FETCH};
      mem_ready = 1'b1; opcode = 6'h00; funct = 6'h22;
      foreach (seq[i]) sb.push_back(mk(seq[i], 1'b0, 2'b00));
      for (int i = 0; i < 5; i++) begin
         tick();
         e = sb.pop_front();
         total++;
         if (dut_vec !== exp_vec(e)) begin
            bad++; $display("FAIL rtype[%0d]: got %h want %h", i, dut_vec, exp_vec(e));
         end
         total++;
         if (RegWrite !== (e.st == WB_R) || RegDst !== (e.st == WB_R)) begin
            bad++; $display("FAIL rtype_wb[%0d]: got RegWrite=%b RegDst=%b want %b", i, RegWrite, RegDst, e.st == WB_R);
         end
         if (e.st == EXEC_R) begin
            total++;
            if (ALUCtrl !== 4'b0110) begin
               bad++; $display("FAIL rtype_aluctrl: got %b want 0110", ALUCtrl);
            end
         end
      end
   endtask

   task automatic test_lw_wait();
      logic [3:0] seq [8] = '{DECODE, MEM_ADDR, MEM_RD, MEM_RD, MEM_RD, MEM_RD, WB_MEM, FETCH};
      logic       mr  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      opcode = 6'h23;
      foreach (seq[i]) sb.push_back(mk(seq[i], 1'b0, 2'b00));
      for (int i = 0; i < 8; i++) begin
         tick();
         mem_ready = mr[i];
         #1;
         e = sb.pop_front();
         total++;
         if (dut_vec !== exp_vec(e)) begin
            bad++; $display("FAIL lw[%0d]: got %h want %h", i, dut_vec, exp_vec(e));
         end
         if (e.st == MEM_RD) begin
            total++;
            if (MemRead !== 1'b1 || IorD !== 1'b1) begin
               bad++; $display("FAIL lw_memrd[%0d]: got MemRead=%b IorD=%b want 1 1", i, MemRead, IorD);
            end
         end
         if (e.st == WB_MEM) begin
            total++;
            if (MemtoReg !== 1'b1) begin
               bad++; $display("FAIL lw_wb: got MemtoReg=%b want 1", MemtoReg);
            end
         end
      end
   endtask

   task automatic test_beq();
      logic [3:0] seq [3] = '{DECODE, BRANCH, FETCH};
      opcode = 6'h04;
      for (int z = 1; z >= 0; z--) begin
         zero = z[0];
         foreach (seq[i]) sb.push_back(mk(seq[i], 1'b0, 2'b00));
         for (int i = 0; i < 3; i++) begin
            tick();
            e = sb.pop_front();
            total++;
            if (dut_vec !== exp_vec(e)) begin
               bad++; $display("FAIL beq_z%0d[%0d]: got %h want %h", z, i, dut_vec, exp_vec(e));
            end
            if (e.st == BRANCH) begin
               total++;
               if (pc_en !== z[0]) begin
                  bad++; $display("FAIL beq_pc_en_z%0d: got %b want %b", z, pc_en, z[0]);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      // sw, addi, j, R/or, R/unknown funct
      logic [3:0] seq [18] = '{DECODE, MEM_ADDR, MEM_WR, FETCH,
                               DECODE, EXEC_I, WB_I, FETCH,
                               DECODE, JUMP, FETCH,
                               DECODE, EXEC_R, WB_R, FETCH,
                               DECODE, EXEC_R, WB_R};
      logic [5:0] op  [18] = '{6'h2B, 6'h2B, 6'h2B, 6'h08,
                               6'h08, 6'h08, 6'h08, 6'h02,
                               6'h02, 6'h02, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00};
      logic [5:0] fn  [18] = '{6'h00, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h25,
                               6'h25, 6'h25, 6'h25, 6'h03,
                               6'h03, 6'h03, 6'h03};
      mem_ready = 1'b1; zero = 1'b0; opcode = 6'h2B;
      foreach (seq[i]) sb.push_back(mk(seq[i], 1'b0, 2'b00));
      for (int i = 0; i < 18; i++) begin
         tick();
         opcode = op[i];
         funct  = fn[i];
         #1;
         e = sb.pop_front();
         total++;
         if (dut_vec !== exp_vec(e)) begin
            bad++; $display("FAIL b2b[%0d]: got %h want %h", i, dut_vec, exp_vec(e));
         end
      end
   endtask

   task automatic test_illegal();
      opcode = 6'h3F;
      sb.push_back(mk(FETCH, 1'b0, 2'b00));
      sb.push_back(mk(DECODE, 1'b0, 2'b00));
      for (int i = 0; i < 20; i++) sb.push_back(mk(TRAP, 1'b1, 2'b01));
      for (int i = 0; i < 22; i++) begin
         tick();
         e = sb.pop_front();
         total++;
         if (dut_vec !== exp_vec(e)) begin
            bad++; $display("FAIL illegal[%0d]: got %h want %h", i, dut_vec, exp_vec(e));
         end
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (state_o !== IDLE || trap !== 1'b0 || trap_cause !== 2'b00) begin
         bad++; $display("FAIL trap_reset: got st=%0d trap=%b cause=%b want 0 0 00", state_o, trap, trap_cause);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_timeout();
      mem_ready = 1'b0; opcode = 6'h00; funct = 6'h20;
      for (int i = 0; i < 16; i++) sb.push_back(mk(FETCH, 1'b0, 2'b00));
      sb.push_back(mk(TRAP, 1'b1, 2'b10));
      for (int i = 0; i < 17; i++) begin
         tick();
         e = sb.pop_front();
         total++;
         if (dut_vec !== exp_vec(e)) begin
            bad++; $display("FAIL timeout[%0d]: got %h want %h", i, dut_vec, exp_vec(e));
         end
      end
      #2 rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      // ready arrives on the last allowed cycle: success, no trap
      for (int i = 0; i < 16; i++) sb.push_back(mk(FETCH, 1'b0, 2'b00));
      sb.push_back(mk(DECODE, 1'b0, 2'b00));
      sb.push_back(mk(EXEC_R, 1'b0, 2'b00));
      sb.push_back(mk(WB_R, 1'b0, 2'b00));
      sb.push_back(mk(FETCH, 1'b0, 2'b00));
      for (int i = 0; i < 20; i++) begin
         tick();
         mem_ready = (i >= 15);
         #1;
         e = sb.pop_front();
         total++;
         if (dut_vec !== exp_vec(e)) begin
            bad++; $display("FAIL late_ready[%0d]: got %h want %h", i, dut_vec, exp_vec(e));
         end
      end
   endtask

   task automatic test_async_mem_wr();
      logic [3:0] seq [3] = '{DECODE, MEM_ADDR, MEM_WR};
      logic       mr  [3] = '{1'b1, 1'b1, 1'b0};
      opcode = 6'h2B; mem_ready = 1'b1;
      foreach (seq[i]) sb.push_back(mk(seq[i], 1'b0, 2'b00));
      for (int i = 0; i < 3; i++) begin
         tick();
         mem_ready = mr[i];
         #1;
         e = sb.pop_front();
         total++;
         if (dut_vec !== exp_vec(e)) begin
            bad++; $display("FAIL sw_wait[%0d]: got %h want %h", i, dut_vec, exp_vec(e));
         end
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (MemWrite !== 1'b0 || state_o !== IDLE) begin
         bad++; $display("FAIL async_reset: got MemWrite=%b st=%0d want 0 0", MemWrite, state_o);
      end
      tick();
      rst_n = 1'b1;
      mem_ready = 1'b1;
      tick();
      total++;
      if (state_o !== FETCH) begin
         bad++; $display("FAIL restart: got st=%0d want %0d", state_o, FETCH);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_wait();
      test_beq();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_async_mem_wr();
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Next-generation MIPS control unit: replaces the single-cycle opcode ROM plus ALU-control mux with a multicycle Moore FSM.
- Sequences FETCH/DECODE/EXEC/MEM/WB over several cycles and supports variable-latency memory through a ready handshake with a timeout.
- Traps on illegal opcodes.
- Drives the multicycle datapath (PC, IR, register file, ALU, unified memory) and embeds ALU-control decode.

Parameters:
- OPC_W, 6, opcode and funct field width.
- ALUCTRL_W, 4, ALU control code width.
- WAIT_MAX, 15, max cycles to wait for mem_ready before a timeout trap (1..255).
- CNT_W, 8, wait-counter width; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPC_W  IR[31:26], valid from DECODE onward.
- funct  in  OPC_W  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if zero.
- pc_en  out  1  PCWrite | (PCWriteCond & zero).
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead, MemWrite  out  1  memory strobes.
- IRWrite  out  1  IR load.
- MemtoReg, RegDst, RegWrite, ALUSrcA  out  1  datapath selects.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext, 11 = signext<<2.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct.
- ALUCtrl  out  ALUCTRL_W  decoded ALU operation.
- trap  out  1  sticky error flag.
- trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = mem timeout.
- state_o  out  4  current state, for debug.

Behaviour:
Reset
- Asynchronous, active-low.
- State = IDLE, wait counter = 0, trap = 0, trap_cause = 00.
- In IDLE all outputs are 0, except ALUCtrl = decode of ALUOp 00 (0010).
- IDLE -> FETCH unconditionally on the first clock edge after rst_n deasserts.

Outputs
- All outputs are Moore functions of the state.
- Exceptions: IRWrite and PCWrite in FETCH, which are qualified by mem_ready.
- Any output not listed for a state is 0.

State encodings and actions
- FETCH(1): MemRead, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00. IRWrite and PCWrite = mem_ready. Stays while !mem_ready; goes to DECODE when mem_ready.
- DECODE(2): ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00. Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x23, 0x2B -> MEM_ADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> EXEC_I
  - anything else -> TRAP with cause 01
- MEM_ADDR(3): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Goes to MEM_RD if opcode = 0x23, otherwise MEM_WR.
- MEM_RD(4): MemRead, IorD = 1. Waits for mem_ready, then goes to WB_MEM.
- WB_MEM(5): RegWrite, MemtoReg = 1, RegDst = 0. Goes to FETCH.
- MEM_WR(6): MemWrite, IorD = 1. Waits for mem_ready, then goes to FETCH.
- EXEC_R(7): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Goes to WB_R.
- WB_R(8): RegWrite, RegDst = 1, MemtoReg = 0. Goes to FETCH.
- BRANCH(9): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond, PCSource = 01. Goes to FETCH.
- JUMP(10): PCWrite, PCSource = 10. Goes to FETCH.
- EXEC_I(11): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Goes to WB_I.
- WB_I(12): RegWrite, RegDst = 0, MemtoReg = 0. Goes to FETCH.
- TRAP(15): all strobes 0. Absorbing; only reset exits.
- Unused encodings go to TRAP with cause 01.

Wait counter
- Cleared on entry to FETCH, MEM_RD or MEM_WR.
- Increments each cycle in those states while !mem_ready.
- If counter == WAIT_MAX and !mem_ready: go to TRAP with cause 10.
  - A write strobe in flight is dropped that cycle.
- mem_ready arriving on the same cycle the counter reaches WAIT_MAX counts as success; no trap.

trap and trap_cause
- Both are set on entry to TRAP and held until reset.

ALUCtrl
- Combinational.
- ALUOp 00 -> 0010.
- ALUOp 01 -> 0110.
- ALUOp 10, decoded by funct:
  - 0x20 -> 0010
  - 0x22 -> 0110
  - 0x24 -> 0000
  - 0x25 -> 0001
  - 0x2A -> 0111
  - any other funct -> 1111 (no trap)
- ALUOp 11 -> 1111.
- Codes are zero-extended when ALUCTRL_W > 4.

Cycle counts with mem_ready tied high
- R-type: 4 cycles
- lw: 5 cycles
- sw: 4 cycles
- beq: 3 cycles
- j: 3 cycles
- addi: 4 cycles

Decomposition:
- Shared package mcc_pkg holds:
  - the state enum (4-bit) with the encodings above;
  - opcode constants OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - funct constants;
  - ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_BAD;
  - ALUSrcB and PCSource encodings.
- One sub-module, alu_ctrl_dec: combinational ALUOp/funct -> ALUCtrl, instantiated once.

Test Plan:
- Reset, mem_ready = 1, opcode 0x00 / funct 0x22 -> state sequence IDLE, FETCH, DECODE, EXEC_R, WB_R, FETCH. ALUCtrl = 0110 in EXEC_R; RegWrite = 1 and RegDst = 1 only in WB_R.
- lw (0x23) with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, MemRead = 1 and IorD = 1 throughout, then WB_MEM with MemtoReg = 1.
- beq (0x04): zero = 1 -> pc_en = 1 in BRANCH; zero = 0 -> pc_en = 0. Both take 3 cycles.
- opcode 0x3F -> DECODE goes to TRAP; trap = 1 and trap_cause = 01 persist 20 cycles; pulse rst_n low mid-TRAP -> IDLE, trap = 0.
- mem_ready held low in FETCH, WAIT_MAX = 15 -> TRAP with cause 10 after the 16th FETCH cycle. Repeat with mem_ready rising on that 16th cycle -> DECODE, no trap.
- Async reset asserted mid MEM_WR, off-edge -> MemWrite drops immediately and state_o = 0 before the next clk edge.
